// File: rtl/instr_assembler.sv
// instr_assembler: packs decoded RV32I fields into instruction words and streams them
// through a small FIFO into instruction memory. Optional feature macro: ILLEGAL_OPCODE_CHECK_EN.
module instr_assembler #(
    parameter int DEPTH = 4,
    parameter int AW    = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [31:0]   base_pc,
    input  logic [15:0]   num_instr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    fmt,
    input  logic [6:0]    opcode,
    input  logic [4:0]    rd,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    input  logic [2:0]    funct3,
    input  logic [6:0]    funct7,
    input  logic [31:0]   imm,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    input  logic          imem_wready,
    output logic          busy,
    output logic          done,
    output logic          wrap
`ifdef ILLEGAL_OPCODE_CHECK_EN
    ,
    output logic          illegal
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [15:0]     acc_cnt_q, acc_cnt_d;
    logic [15:0]     wr_cnt_q, wr_cnt_d;
    logic [15:0]     num_q, num_d;
    logic            wrap_q, wrap_d;
    logic            illegal_q, illegal_d;

    logic [31:0]     mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW:0]     count_q, count_d;

    logic [31:0]     enc_word;
    logic            run;
    logic            fifo_empty;
    logic            fifo_full;
    logic            accept;
    logic            legal;
    logic            push;
    logic            skip;
    logic            pop;
    logic            unused_ok;

    // Bits of base_pc outside the word-address window never matter.
    assign unused_ok = ^{base_pc[31:AW+2], base_pc[1:0]};

    always_comb begin
        enc_word = '0;
        case (fmt)
            2'b00:   enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            2'b01:   enc_word = {imm[11:0], rs1, funct3, rd, opcode};
            2'b10:   enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            default: enc_word = {imm[31:12], rd, opcode};
        endcase
    end

`ifdef ILLEGAL_OPCODE_CHECK_EN
    assign legal   = (opcode[1:0] == 2'b11);
    assign illegal = illegal_q;
`else
    assign legal   = 1'b1;
`endif

    assign run        = (state_q == S_RUN);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (PW+1)'(DEPTH));

    // A full FIFO refuses a push even if a pop frees a slot in the same cycle.
    assign in_ready   = run && !fifo_full && (acc_cnt_q < num_q);
    assign accept     = in_valid && in_ready;
    assign push       = accept && legal;
    assign skip       = accept && !legal;

    assign imem_we    = run && !fifo_empty;
    assign pop        = imem_we && imem_wready;
    assign imem_waddr = addr_q;
    assign imem_wdata = imem_we ? mem_q[rptr_q] : 32'h0;

    assign busy       = run;
    assign done       = (state_q == S_DONE);
    assign wrap       = wrap_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        acc_cnt_d = acc_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        num_d     = num_q;
        wrap_d    = wrap_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d    = base_pc[AW+1:2];
                    acc_cnt_d = '0;
                    wr_cnt_d  = '0;
                    num_d     = num_instr;
                    wrap_d    = 1'b0;
                    illegal_d = 1'b0;
                    state_d   = (num_instr == 16'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    acc_cnt_d = acc_cnt_q + 16'd1;
                end
                if (skip) begin
                    illegal_d = 1'b1;
                end
                if (pop) begin
                    addr_d = addr_q + 1'b1;
                    if (&addr_q) begin
                        wrap_d = 1'b1;
                    end
                end
                // Skipped bundles count as written so an all-illegal session still ends.
                wr_cnt_d = wr_cnt_q + 16'(pop) + 16'(skip);
                if ((pop || skip) && (wr_cnt_d == num_q)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            num_q     <= '0;
            wrap_q    <= 1'b0;
            illegal_q <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            acc_cnt_q <= acc_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            num_q     <= num_d;
            wrap_q    <= wrap_d;
            illegal_q <= illegal_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= enc_word;
        end
    end

endmodule

// File: doc/instr_assembler.md
Name: instr_assembler

Overview:
- Inverse of the core's field-extraction path: accepts decoded RISC-V fields (opcode, rd, rs1, rs2, funct3, funct7, imm) through a valid/ready handshake.
- Packs them into 32-bit RV32I instruction words (R/I/S/U formats).
- Buffers words in a small FIFO and writes them sequentially into instruction memory, using word addresses derived from a byte PC (pc[21:2]).
- Serves as the program loader / self-test instruction generator feeding instruction memory before the core runs.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2)
- AW, 20, instruction-memory word-address width (matches pc[21:2])

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins a load session
- base_pc  in  32  byte address of first instruction; sampled on start
- num_instr  in  16  instructions in session; sampled on start
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted when in_valid && in_ready
- fmt  in  2  00=R, 01=I, 10=S, 11=U
- opcode  in  7  opcode
- rd, rs1, rs2  in  5 each  register fields
- funct3  in  3  funct3
- funct7  in  7  funct7 (R only)
- imm  in  32  immediate (I/S use [11:0], U uses [31:12])
- imem_we  out  1  write request
- imem_waddr  out  AW  word address
- imem_wdata  out  32  instruction word
- imem_wready  in  1  memory accepts write when imem_we && imem_wready
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when the last word is written
- wrap  out  1  sticky; address counter wrapped past 2^AW-1

Behaviour:
- Reset (asynchronous, rst=1): state IDLE; FIFO empty; counters 0; in_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, busy=0, done=0, wrap=0.
- Encoding, combinational on the input bundle, written into the FIFO on acceptance:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - U: {imm[31:12], rd, opcode}
  - Unused fields are ignored.
- FSM:
  - IDLE: on start, load addr=base_pc[AW+1:2], acc_cnt=0, wr_cnt=0, clear wrap, then go to RUN. If num_instr==0, go to DONE instead.
  - RUN: in_ready = !fifo_full && (acc_cnt < num_instr). When wr_cnt reaches num_instr on a write handshake, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - start is ignored outside IDLE.
- Write port:
  - imem_we = FIFO non-empty in RUN.
  - imem_wdata = FIFO head; imem_waddr = addr register.
  - Both are held stable while imem_we && !imem_wready.
  - On handshake: pop FIFO, addr+1, wr_cnt+1.
- Latency: a bundle accepted in cycle N can appear on imem_we in cycle N+1 at the earliest (registered FIFO). Throughput is 1 word/cycle with imem_wready held high.
- Simultaneous push and pop when full: push is not allowed (in_ready=0 while full, even if a pop occurs that cycle). Push and pop together when non-full and non-empty: the count is unchanged.
- Address wrap: addr 2^AW-1 increments to 0 and sets wrap=1 (sticky until next start). Writing continues.
- Reset mid-session: aborts immediately; FIFO contents are discarded; no done pulse.

Optional Feature:
- Macro ILLEGAL_OPCODE_CHECK_EN.
- Defined:
  - A bundle with opcode[1:0] != 2'b11 is accepted (handshake completes) but not pushed.
  - It still counts toward acc_cnt and wr_cnt, so the session terminates.
  - Adds output illegal (1 bit, sticky, cleared on start/reset).
- Undefined: every bundle is encoded and written verbatim; the illegal port is absent.

Test Plan:
- R-type: start base_pc=0x100, num_instr=1. Bundle fmt=R, opcode=0x33, rd=3, rs1=1, rs2=2, funct3=0, funct7=0 → imem_waddr=0x00040, imem_wdata=0x002081B3, done one cycle after the write.
- I/S/U sequence, num_instr=3, imem_wready=1:
  - addi x5,x0,-1 (imm=0xFFFFFFFF) → 0xFFF00293 @0x00040
  - sw x2,8(x1) (funct3=2, opcode 0x23) → 0x0020A423 @0x00041
  - lui x1,0x12345 (imm=0x12345000, opcode 0x37) → 0x123450B7 @0x00042
- Backpressure: imem_wready=0 for 10 cycles, 6 bundles offered → exactly DEPTH=4 accepted, in_ready=0. imem_we/addr/data stay stable. Release → 6 words written in order, done pulse.
- Wrap: base_pc=0x003FFFFC, num_instr=2 → writes at 0xFFFFF then 0x00000, wrap=1.
- Edge cases:
  - num_instr=0 → done the cycle after start, no imem_we.
  - start during RUN → ignored.
  - rst asserted mid-session → all outputs are reset values on the same edge, and no done pulse.
